ex_mem: RTL
===========

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter CNT_W, default 32, width of the committed-write counter.
REQ-002 Clk  input  1  single clock, all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  6  pipeline stall vector; bit 3 = EX stage held, bit 4 = MEM stage held.
REQ-005 flush  input  1  discard in-flight EX result (exception/redirect).
REQ-006 ex_wd  input  5  EX destination register address.
REQ-007 ex_wreg  input  1  EX write-enable.
REQ-008 ex_wdata  input  32  EX result data.
REQ-009 mem_wd  output  5  registered destination address to MEM.
REQ-010 mem_wreg  output  1  registered write-enable to MEM.
REQ-011 mem_wdata  output  32  registered result data to MEM.
REQ-012 mem_valid  output  1  registered slot holds a real instruction (not bubble).
REQ-013 fwd_hit  output  1  combinational: mem_valid & mem_wreg & (mem_wd != 0).
REQ-014 commit_cnt  output  CNT_W  count of valid write-enabled slots accepted into MEM.

Function
REQ-015 Register update priority, highest first: Rst, flush, bubble, hold, advance.
REQ-016 Flush: on edge with flush=1, mem_wd=0, mem_wreg=0, mem_wdata=0, mem_valid=0, regardless of stall.
REQ-017 Bubble: stall[3]=1 & stall[4]=0 -> same zero values as flush; EX contents not captured.
REQ-018 Hold: stall[3]=1 & stall[4]=1 -> all registered outputs keep previous values.
REQ-019 Advance: stall[3]=0 -> capture ex_wd, ex_wreg, ex_wdata; mem_valid=1.
REQ-020 stall[3]=0 & stall[4]=1 is illegal; block SHALL treat it as advance (no assertion-only behaviour).
REQ-021 Latency: exactly one Clk edge from EX inputs to MEM outputs on advance.
REQ-022 commit_cnt increments by 1 on each advance edge where ex_wreg=1 and ex_wd != 0; not on flush, bubble, hold.
REQ-023 commit_cnt wraps modulo 2^CNT_W (all-ones + 1 -> 0), no saturation.
REQ-024 Writes to register 0 SHALL pass through unchanged in mem_wd/mem_wreg but SHALL NOT assert fwd_hit nor count.
REQ-025 fwd_hit derived only from registered outputs; no combinational path from ex_* to any output.
REQ-026 flush and advance on same edge: flush wins, counter unchanged.

Reset
REQ-027 Rst=1 asynchronously forces mem_wd=0, mem_wreg=0, mem_wdata=0, mem_valid=0, commit_cnt=0, independent of Clk.
REQ-028 Reset asserted mid-hold discards held slot; first edge after Rst deassert follows REQ-015 normally.
REQ-029 All outputs defined (no X) while Rst=1.

Verification
REQ-030 Advance: stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234_5678 -> next edge mem_wd=5, mem_wdata=0x12345678, mem_valid=1, fwd_hit=1, commit_cnt=1.
REQ-031 Bubble then hold: stall=6'b001000 one edge -> outputs zero, mem_valid=0; then stall=6'b011000 three edges with new EX values -> outputs stay zero, commit_cnt unchanged.
REQ-032 Flush priority: flush=1, stall=0, ex_wd=7, ex_wreg=1 -> outputs zero, commit_cnt unchanged.
REQ-033 r0 write: ex_wd=0, ex_wreg=1, ex_wdata=0xFFFF_FFFF, stall=0 -> mem_wreg=1, mem_wdata=0xFFFFFFFF, fwd_hit=0, commit_cnt unchanged.
REQ-034 Wrap: CNT_W=4, 16 consecutive counted advances from reset -> commit_cnt=0.
REQ-035 Async reset: assert Rst between edges while mem_valid=1 -> all outputs zero before next Clk edge.

Source files
------------

// File: rtl/ex_mem.sv
// EX/MEM pipeline register. It carries the EX result into the MEM stage, supports
// flush, bubble and hold, and counts the committed register writes.
module ex_mem #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic [4:0]       ex_wd,
    input  logic             ex_wreg,
    input  logic [31:0]      ex_wdata,
    output logic [4:0]       mem_wd,
    output logic             mem_wreg,
    output logic [31:0]      mem_wdata,
    output logic             mem_valid,
    output logic             fwd_hit,
    output logic [CNT_W-1:0] commit_cnt
);

    localparam logic [1:0] MODE_ADVANCE = 2'd0;
    localparam logic [1:0] MODE_HOLD    = 2'd1;
    localparam logic [1:0] MODE_BUBBLE  = 2'd2;
    localparam logic [1:0] MODE_FLUSH   = 2'd3;

    logic [1:0]       mode_s;
    logic             count_en_s;
    logic [4:0]       wd_d,    wd_q;
    logic             wreg_d,  wreg_q;
    logic [31:0]      wdata_d, wdata_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;

    // Select the slot action for this edge. Stall with EX moving but MEM held is treated as advance.
    always_comb begin
        mode_s = MODE_ADVANCE;
        if (flush) begin
            mode_s = MODE_FLUSH;
        end else if (stall[3] && !stall[4]) begin
            mode_s = MODE_BUBBLE;
        end else if (stall[3]) begin
            mode_s = MODE_HOLD;
        end else begin
            mode_s = MODE_ADVANCE;
        end
    end

    // Compute the next slot contents and the counter update.
    always_comb begin
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        valid_d    = valid_q;
        count_en_s = 1'b0;
        case (mode_s)
            MODE_FLUSH, MODE_BUBBLE: begin
                wd_d    = 5'd0;
                wreg_d  = 1'b0;
                wdata_d = 32'd0;
                valid_d = 1'b0;
            end
            MODE_HOLD: begin
                wd_d    = wd_q;
                wreg_d  = wreg_q;
                wdata_d = wdata_q;
                valid_d = valid_q;
            end
            MODE_ADVANCE: begin
                wd_d       = ex_wd;
                wreg_d     = ex_wreg;
                wdata_d    = ex_wdata;
                valid_d    = 1'b1;
                count_en_s = ex_wreg && (ex_wd != 5'd0);
            end
            default: begin
                wd_d    = 5'd0;
                wreg_d  = 1'b0;
                wdata_d = 32'd0;
                valid_d = 1'b0;
            end
        endcase
        if (count_en_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Slot and counter registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wd_q    <= 5'd0;
            wreg_q  <= 1'b0;
            wdata_q <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Forwarding uses only the registered slot, so no EX input can reach an output combinationally.
    assign fwd_hit    = valid_q & wreg_q & (wd_q != 5'd0);
    assign mem_wd     = wd_q;
    assign mem_wreg   = wreg_q;
    assign mem_wdata  = wdata_q;
    assign mem_valid  = valid_q;
    assign commit_cnt = cnt_q;

endmodule
